cdb_arbiter: RTL and testbench

Round-robin arbiter and output register for the common data bus (CDB). It sits between the functional units (ALU, memory functional unit, MMU return path) and every CDB consumer: reservation stations, register file bypass and reorder buffer. It replaces combinational fixed-priority CDB selection with fair, registered arbitration, and adds flush handling and performance counters.

---
 rtl/fcpu_pkg.sv | 17 +
 rtl/rr_select.sv | 34 +++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// Shared CPU-wide widths and CDB unit indices.
// A CDB word is {tag, value}, with the tag in the upper RSV_ID_W bits.
package fcpu_pkg;
  localparam int RSV_ID_W    = 4;
  localparam int DATA_W      = 32;
  localparam int CDB_W       = RSV_ID_W + DATA_W;

  localparam int N_CDB_UNITS = 3;
  localparam int CDB_ALU     = 0;
  localparam int CDB_MFU     = 1;
  localparam int CDB_MMU     = 2;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_word_t;
endpackage

// File: rtl/rr_select.sv
// Round-robin priority encoder: the first set req bit at or after ptr wins,
// wrapping modulo N. Pure combinational, reusable for issue selection.
module rr_select #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);
  logic [2*N-1:0] rot;
  logic [IDX_W:0] sum;

  // Doubling the request vector lets a plain shift express the wrap.
  assign rot = {req, req} >> ptr;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      end
    end
    index = sum[IDX_W-1:0];
    if (any) grant[index] = 1'b1;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Registered round-robin CDB arbiter with flush handling and per-unit
// grant / conflict performance counters.
module cdb_arbiter #(
  parameter int N_UNITS = fcpu_pkg::N_CDB_UNITS,
  parameter int CDB_W   = fcpu_pkg::CDB_W,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              flush,
  input  logic [N_UNITS-1:0][CDB_W-1:0]     req_cdb,
  input  logic [N_UNITS-1:0]                req_valid,
  output logic [N_UNITS-1:0]                req_ready,
  output logic [CDB_W-1:0]                  cdb,
  output logic                              cdb_valid,
  output logic [IDX_W-1:0]                  cdb_unit,
  output logic [N_UNITS-1:0][CNT_W-1:0]     grant_cnt,
  output logic [CNT_W-1:0]                  conflict_cnt
);
  import fcpu_pkg::*;

  logic [N_UNITS-1:0] sel_req, sel_gnt;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CDB_W-1:0]   cdb_q, cdb_d;
  logic [IDX_W-1:0]   unit_q, unit_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   conf_q;
  logic [IDX_W:0]     n_valid;
  logic               conflict;

  // Gating the request side keeps req_ready low during reset and flush
  // without any path from req_cdb.
  assign sel_req = (nrst && !flush) ? req_valid : '0;

  rr_select #(.N(N_UNITS), .IDX_W(IDX_W)) u_sel (
    .req   (sel_req),
    .ptr   (rr_ptr_q),
    .grant (sel_gnt),
    .index (sel_idx),
    .any   (sel_any)
  );

  assign req_ready = sel_gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_d    = cdb_q;
    unit_d   = unit_q;
    vld_d    = 1'b0;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (sel_any) begin
      vld_d    = 1'b1;
      cdb_d    = req_cdb[sel_idx];
      unit_d   = sel_idx;
      rr_ptr_d = (sel_idx == IDX_W'(N_UNITS-1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_comb begin
    n_valid = '0;
    for (int i = 0; i < N_UNITS; i++) n_valid = n_valid + (IDX_W+1)'(req_valid[i]);
  end

  assign conflict = !flush && (n_valid > (IDX_W+1)'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
      unit_q   <= '0;
      vld_q    <= 1'b0;
      conf_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
      unit_q   <= unit_d;
      vld_q    <= vld_d;
      if (conflict) conf_q <= conf_q + 1'b1;
    end
  end

  for (genvar u = 0; u < N_UNITS; u++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)           cnt_q <= '0;
      else if (sel_gnt[u]) cnt_q <= cnt_q + 1'b1;
    end
    assign grant_cnt[u] = cnt_q;
  end

  assign cdb          = cdb_q;
  assign cdb_valid    = vld_q;
  assign cdb_unit     = unit_q;
  assign conflict_cnt = conf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference round-robin model queues the
// expected broadcast per cycle; a negedge monitor pops and compares.
module tb_cdb_arbiter;
  localparam int N = 3;
  localparam int W = 36;
  localparam int C = 32;

  logic                clk = 1'b0;
  logic                nrst;
  logic                flush;
  logic [N-1:0][W-1:0] req_cdb;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [W-1:0]        cdb;
  logic                cdb_valid;
  logic [1:0]          cdb_unit;
  logic [N-1:0][C-1:0] grant_cnt;
  logic [C-1:0]        conflict_cnt;

  cdb_arbiter #(.N_UNITS(N), .CDB_W(W), .CNT_W(C)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .req_cdb(req_cdb),
    .req_valid(req_valid), .req_ready(req_ready), .cdb(cdb),
    .cdb_valid(cdb_valid), .cdb_unit(cdb_unit), .grant_cnt(grant_cnt),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [1:0]   unit;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  int           m_ptr;
  logic [C-1:0] m_gcnt[N];
  logic [C-1:0] m_conf;
  logic [W-1:0] m_cdb;
  logic [1:0]   m_unit;

  task automatic model_reset();
    m_ptr = 0; m_conf = '0; m_cdb = '0; m_unit = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = '0;
    q.delete();
  endtask

  // Monitor: item pushed in cycle t is checked at the negedge of cycle t+1.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      total_cnt++;
      if (cdb_valid !== ce.vld) $display("FAIL cdb_valid: got %b want %b @%0t", cdb_valid, ce.vld, $time);
      else pass_cnt++;
      total_cnt++;
      if (cdb !== ce.data) $display("FAIL cdb: got %h want %h @%0t", cdb, ce.data, $time);
      else pass_cnt++;
      total_cnt++;
      if (cdb_unit !== ce.unit) $display("FAIL cdb_unit: got %0d want %0d @%0t", cdb_unit, ce.unit, $time);
      else pass_cnt++;
    end
  end

  // Drive one cycle from a negedge, check req_ready, advance the model.
  task automatic tick(input logic [N-1:0] v, input logic f);
    logic [N-1:0] exp_rdy;
    int g;
    req_valid = v;
    flush     = f;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!f)
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    total_cnt++;
    if (req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b @%0t", req_ready, exp_rdy, $time);
    else pass_cnt++;
    if (!f && $countones(v) >= 2) m_conf = m_conf + 1'b1;
    if (g >= 0) begin
      m_cdb  = req_cdb[g];
      m_unit = 2'(g);
      m_gcnt[g] = m_gcnt[g] + 1'b1;
      m_ptr  = (g + 1) % N;
    end else if (f) begin
      m_ptr = 0;
    end
    q.push_back('{vld: (g >= 0), unit: m_unit, data: m_cdb});
    @(negedge clk);
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < N; i++) begin
      total_cnt++;
      if (grant_cnt[i] !== m_gcnt[i])
        $display("FAIL %s grant_cnt[%0d]: got %0d want %0d", tag, i, grant_cnt[i], m_gcnt[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (conflict_cnt !== m_conf) $display("FAIL %s conflict_cnt: got %0d want %0d", tag, conflict_cnt, m_conf);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nrst = 1'b0; flush = 1'b0; req_valid = 3'b111;
    for (int i = 0; i < N; i++) req_cdb[i] = W'(i + 1);
    model_reset();
    #2;
    total_cnt++;
    if (req_ready !== 3'b000) $display("FAIL reset req_ready: got %b want 000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (cdb_valid !== 1'b0 || cdb !== '0 || cdb_unit !== 2'd0)
      $display("FAIL reset outputs: got v=%b cdb=%h u=%0d want 0/0/0", cdb_valid, cdb, cdb_unit);
    else pass_cnt++;
    check_counters("reset");
    req_valid = '0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) req_cdb[i] = W'(i + 1);
    for (int c = 0; c < 6; c++) tick(3'b111, 1'b0);
    check_counters("rr");
  endtask

  task automatic test_single_unit();
    for (int c = 0; c < 4; c++) tick(3'b100, 1'b0);
    check_counters("single");
    tick(3'b111, 1'b0);
    tick(3'b000, 1'b0);
  endtask

  task automatic test_flush();
    tick(3'b111, 1'b0);
    tick(3'b011, 1'b1);
    tick(3'b011, 1'b0);
    tick(3'b000, 1'b0);
    check_counters("flush");
  endtask

  task automatic test_hold();
    req_cdb[0] = 36'hA_0000_00AA;
    req_cdb[1] = 36'hB_0000_00BB;
    tick(3'b011, 1'b0);
    tick(3'b010, 1'b0);
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++) req_cdb[i] = {4'($urandom), 32'($urandom)};
      tick(3'($urandom), ($urandom_range(0, 7) == 0));
    end
    tick(3'b000, 1'b0);
    check_counters("random");
  endtask

  task automatic test_reset_midtraffic();
    req_valid = 3'b111; flush = 1'b0;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (req_ready !== 3'b000 || cdb_valid !== 1'b0)
      $display("FAIL midreset: got rdy=%b v=%b want 000/0", req_ready, cdb_valid);
    else pass_cnt++;
    check_counters("midreset");
    @(negedge clk);
    nrst = 1'b1;
    tick(3'b110, 1'b0);
    tick(3'b000, 1'b0);
  endtask

  task automatic test_wrap();
    force dut.g_cnt[0].cnt_q = '1;
    #1;
    release dut.g_cnt[0].cnt_q;
    m_gcnt[0] = '1;
    tick(3'b001, 1'b0);
    tick(3'b000, 1'b0);
    total_cnt++;
    if (grant_cnt[0] !== '0) $display("FAIL wrap grant_cnt[0]: got %0d want 0", grant_cnt[0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_unit();
    test_flush();
    test_hold();
    test_back_to_back();
    test_reset_midtraffic();
    test_wrap();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
